// File: rtl/instruction_buffer_pkg.sv
// Shared types and sizes for the instruction buffer.
// Fetch packet layout, buffer geometry and small helpers.
package instruction_buffer_pkg;

  localparam int IB_SZ          = 16;
  localparam int IB_IDX_BITS    = $clog2(IB_SZ);
  localparam int DISPATCH_WIDTH = 3;
  localparam int FETCH_WIDTH    = 4;
  localparam int DNUM_BITS      = $clog2(DISPATCH_WIDTH + 1);
  localparam int GHR_BITS       = 8;

  typedef logic [IB_IDX_BITS-1:0] idx_t;
  typedef logic [IB_IDX_BITS:0]   cnt_t;

  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [31:0]         inst;
    logic                is_branch;
    logic                bp_pred_taken;
    logic [31:0]         bp_pred_target;
    logic [GHR_BITS-1:0] bp_ghr_snapshot;
  } FETCH_PACKET;

  function automatic cnt_t cnt_min(input cnt_t a, input cnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ib_lane_compact.sv
// Lane compaction for the instruction buffer.
// Counts valid lanes and gives each lane its packed slot offset.
module ib_lane_compact
  import instruction_buffer_pkg::*;
(
  input  logic [3:0]      valid_i,
  output logic [2:0]      enq_n_o,
  output logic [3:0][1:0] prefix_o
);

  logic [2:0] acc;

  // Running prefix sum over lanes, lane 0 first
  always_comb begin
    acc      = '0;
    prefix_o = '0;
    for (int k = 0; k < 4; k++) begin
      prefix_o[k] = acc[1:0];
      acc         = acc + {2'b00, valid_i[k]};
    end
    enq_n_o = acc;
  end

endmodule

// File: rtl/instruction_buffer.sv
// Circular instruction buffer between fetch and dispatch.
// Packs valid fetch lanes, presents oldest entries in program order.
module instruction_buffer
  import instruction_buffer_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  FETCH_PACKET [FETCH_WIDTH-1:0]    fetch_packet,
  output logic [IB_IDX_BITS:0]             ib_free_slots,
  output FETCH_PACKET [DISPATCH_WIDTH-1:0] dispatch_packet,
  input  logic [DNUM_BITS-1:0]             dispatch_num
);

  localparam cnt_t SZ_C = cnt_t'(IB_SZ);
  localparam cnt_t DW_C = cnt_t'(DISPATCH_WIDTH);

  FETCH_PACKET entries_q [IB_SZ];

  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic [3:0]      lane_v;
  logic [2:0]      enq_n;
  logic [3:0][1:0] prefix;

  cnt_t free_w;
  cnt_t enq_w;
  cnt_t dnum_w;
  cnt_t deq_n;
  logic overflow;
  logic enq_ok;

  // Gather per-lane valids for compaction
  always_comb begin
    lane_v = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lane_v[k] = fetch_packet[k].valid;
    end
  end

  ib_lane_compact u_compact (
    .valid_i  (lane_v),
    .enq_n_o  (enq_n),
    .prefix_o (prefix)
  );

  // Free space is from registered count only
  assign free_w        = SZ_C - count_q;
  assign ib_free_slots = free_w;

  assign enq_w    = cnt_t'(enq_n);
  assign dnum_w   = cnt_t'(dispatch_num);
  assign overflow = enq_w > free_w;
  assign enq_ok   = !overflow && !flush && !reset;
  assign deq_n    = cnt_min(cnt_min(dnum_w, DW_C), count_q);

  // Next pointers and occupancy; flush wins over enq/deq
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + idx_t'(deq_n);
      count_d = count_q - deq_n;
      if (enq_ok) begin
        tail_d  = tail_q + idx_t'(enq_w);
        count_d = count_d + enq_w;
      end
    end
  end

  // Pointer and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write valid lanes into consecutive slots from tail
  always_ff @(posedge clock) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (enq_ok && lane_v[k]) begin
        entries_q[tail_q + idx_t'(prefix[k])] <= fetch_packet[k];
      end
    end
  end

  // Present head entries; valid only for occupied slots
  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      dispatch_packet[i]       = entries_q[head_q + idx_t'(i)];
      dispatch_packet[i].valid = cnt_t'(i) < count_q;
    end
  end

  // Fetch must never overfill; dispatch must not over-consume
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      assert (!overflow)
        else $warning("ib overflow: %0d lanes, %0d free, dropped",
                      enq_n, free_w);
      assert (count_q == '0 || (dnum_w <= count_q && dnum_w <= DW_C))
        else $warning("ib dispatch_num %0d clamped, count %0d",
                      dispatch_num, count_q);
    end
  end

endmodule

// File: tb/tb_instruction_buffer.sv
// Testbench for instruction_buffer.
// Directed stimulus, queue scoreboard checked by a negedge monitor.
module tb_instruction_buffer;
  import instruction_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  FETCH_PACKET [FETCH_WIDTH-1:0]    fetch_packet;
  logic [IB_IDX_BITS:0]             ib_free_slots;
  FETCH_PACKET [DISPATCH_WIDTH-1:0] dispatch_packet;
  logic [DNUM_BITS-1:0]             dispatch_num;

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  FETCH_PACKET expq[$];

  always #5 clock = ~clock;

  instruction_buffer dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .fetch_packet    (fetch_packet),
    .ib_free_slots   (ib_free_slots),
    .dispatch_packet (dispatch_packet),
    .dispatch_num    (dispatch_num)
  );

  function automatic FETCH_PACKET mk(input logic v, input logic [31:0] pc);
    FETCH_PACKET p;
    p                 = '0;
    p.valid           = v;
    p.pc              = pc;
    p.inst            = pc ^ 32'hA5A5_0013;
    p.is_branch       = pc[4];
    p.bp_pred_taken   = pc[3];
    p.bp_pred_target  = pc + 32'h0000_0100;
    p.bp_ghr_snapshot = pc[9:2] ^ 8'h3C;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // v[k] is lane k; lane k carries pc base + 4k
  task automatic step(input logic [3:0] v, input logic [31:0] base,
                      input int dn, input logic fl);
    int sz;
    int en;
    int dq;
    for (int k = 0; k < 4; k++)
      fetch_packet[k] = mk(v[k], base + 32'(4 * k));
    dispatch_num = DNUM_BITS'(dn);
    flush        = fl;
    @(posedge clock);
    if (fl) begin
      expq.delete();
    end else begin
      sz = expq.size();
      en = 0;
      for (int k = 0; k < 4; k++) en += int'(v[k]);
      dq = dn;
      if (dq > DISPATCH_WIDTH) dq = DISPATCH_WIDTH;
      if (dq > sz) dq = sz;
      for (int i = 0; i < dq; i++) void'(expq.pop_front());
      if (en <= IB_SZ - sz) begin
        for (int k = 0; k < 4; k++)
          if (v[k]) expq.push_back(mk(1'b1, base + 32'(4 * k)));
      end
    end
    @(negedge clock);
    #1;
  endtask

  // Monitor: compare presented outputs with scoreboard contents
  always @(negedge clock) begin
    if (mon_en) begin
      chk("mon_free", 128'(ib_free_slots), 128'(IB_SZ - expq.size()));
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        if (i < expq.size())
          chk($sformatf("mon_lane%0d", i),
              128'(dispatch_packet[i]), 128'(expq[i]));
        else
          chk($sformatf("mon_v%0d", i),
              128'(dispatch_packet[i].valid), 128'(0));
      end
    end
  end

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    dispatch_num = '0;
    fetch_packet = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_free", 128'(ib_free_slots), 128'(16));
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      chk("rst_valid", 128'(dispatch_packet[i].valid), 128'(0));
    reset  = 1'b0;
    mon_en = 1'b1;
    step(4'b0000, 32'h0, 0, 1'b0);
    chk("idle_free", 128'(ib_free_slots), 128'(16));
    chk("idle_v0", 128'(dispatch_packet[0].valid), 128'(0));

    // aligned full packet
    step(4'b1111, 32'h0, 0, 1'b0);
    chk("al_pc0", 128'(dispatch_packet[0].pc), 128'(32'h0));
    chk("al_pc1", 128'(dispatch_packet[1].pc), 128'(32'h4));
    chk("al_pc2", 128'(dispatch_packet[2].pc), 128'(32'h8));
    chk("al_v2", 128'(dispatch_packet[2].valid), 128'(1));
    chk("al_free", 128'(ib_free_slots), 128'(12));
    step(4'b0000, 32'h0, 0, 1'b1);

    // sparse lanes packed in order
    step(4'b1110, 32'h20, 0, 1'b0);
    step(4'b0001, 32'h40, 0, 1'b0);
    chk("pk_pc0", 128'(dispatch_packet[0].pc), 128'(32'h24));
    chk("pk_pc1", 128'(dispatch_packet[1].pc), 128'(32'h28));
    chk("pk_pc2", 128'(dispatch_packet[2].pc), 128'(32'h2C));
    chk("pk_free", 128'(ib_free_slots), 128'(12));
    step(4'b0000, 32'h0, 3, 1'b0);
    chk("pk_pc3", 128'(dispatch_packet[0].pc), 128'(32'h40));
    chk("pk_free1", 128'(ib_free_slots), 128'(15));
    step(4'b0000, 32'h0, 0, 1'b1);

    // wrap across entry 15 -> 0 with simultaneous enq/deq
    step(4'b1111, 32'h100, 0, 1'b0);
    step(4'b1111, 32'h110, 0, 1'b0);
    step(4'b1111, 32'h120, 0, 1'b0);
    step(4'b0011, 32'h130, 0, 1'b0);
    chk("wr_free14", 128'(ib_free_slots), 128'(2));
    step(4'b0011, 32'h200, 3, 1'b0);
    chk("wr_free13", 128'(ib_free_slots), 128'(3));
    chk("wr_pc0", 128'(dispatch_packet[0].pc), 128'(32'h10C));
    step(4'b0001, 32'h300, 0, 1'b0);
    chk("wr_free_b", 128'(ib_free_slots), 128'(2));
    // overflow: four lanes into two free slots is dropped
    step(4'b1111, 32'h400, 0, 1'b0);
    chk("ov_free", 128'(ib_free_slots), 128'(2));
    for (int i = 0; i < 4; i++) step(4'b0000, 32'h0, 3, 1'b0);
    chk("wr_pc_a", 128'(dispatch_packet[0].pc), 128'(32'h204));
    chk("wr_pc_b", 128'(dispatch_packet[1].pc), 128'(32'h300));
    chk("wr_v2", 128'(dispatch_packet[2].valid), 128'(0));
    step(4'b0000, 32'h0, 1, 1'b0);
    chk("cl_pc", 128'(dispatch_packet[0].pc), 128'(32'h300));
    // over-request clamps to count
    step(4'b0000, 32'h0, 3, 1'b0);
    chk("cl_free", 128'(ib_free_slots), 128'(16));
    chk("cl_v0", 128'(dispatch_packet[0].valid), 128'(0));

    // flush beats same-cycle enq and deq
    step(4'b1111, 32'h500, 0, 1'b0);
    step(4'b1111, 32'h510, 0, 1'b0);
    step(4'b0001, 32'h520, 0, 1'b0);
    chk("fl_free9", 128'(ib_free_slots), 128'(7));
    step(4'b1111, 32'h600, 3, 1'b1);
    chk("fl_free", 128'(ib_free_slots), 128'(16));
    chk("fl_v0", 128'(dispatch_packet[0].valid), 128'(0));
    step(4'b1111, 32'h700, 0, 1'b0);
    chk("fl_pc0", 128'(dispatch_packet[0].pc), 128'(32'h700));
    chk("fl_free12", 128'(ib_free_slots), 128'(12));

    // full buffer still honours dequeue
    step(4'b1111, 32'h710, 0, 1'b0);
    step(4'b1111, 32'h720, 0, 1'b0);
    step(4'b1111, 32'h730, 0, 1'b0);
    chk("fu_free", 128'(ib_free_slots), 128'(0));
    step(4'b1111, 32'h800, 3, 1'b0);
    chk("fu_deq", 128'(ib_free_slots), 128'(3));
    chk("fu_pc0", 128'(dispatch_packet[0].pc), 128'(32'h70C));
    step(4'b0000, 32'h0, 0, 1'b0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
